mdio_phy_ctrl: RTL

//  Clause-22 MDIO master and PHY reset sequencer for the RGMII Ethernet PHY. Runs the
//  phy_resetn power-up sequence, then serialises read/write requests from the PL into
//  MDC/MDIO frames. Drives the mdio_phy_mdio_iobuf IOBUF (I/O/T) and the board phy_resetn pin.

---
 rtl/mdio_phy_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mdio_phy_ctrl.sv
// Clause-22 MDIO master with PHY hardware-reset sequencer.
// Optional MDIO_PREAMBLE_SUPPRESS_EN adds cfg_pre_sup to skip the preamble after the first frame.
module mdio_phy_ctrl #(
    parameter int CLK_DIV      = 40,
    parameter int RST_HOLD_CYC = 2000000,
    parameter int RST_WAIT_CYC = 1000000
) (
    input  logic        clk_200,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        cfg_pre_sup,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done,
    output logic        mdio_phy_mdc,
    input  logic        mdio_phy_mdio_i,
    output logic        mdio_phy_mdio_o,
    output logic        mdio_phy_mdio_t,
    output logic        phy_resetn
);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_MAX = (RST_HOLD_CYC > RST_WAIT_CYC) ? RST_HOLD_CYC : RST_WAIT_CYC;
    localparam int RCNT_W  = $clog2(RST_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(RST_HOLD_CYC - 1);
    localparam logic [RCNT_W-1:0] WAIT_LAST = RCNT_W'(RST_WAIT_CYC - 1);
    localparam logic [6:0] BIT_HDR  = 7'd32;
    localparam logic [6:0] BIT_TA   = 7'd46;
    localparam logic [6:0] BIT_TA2  = 7'd47;
    localparam logic [6:0] BIT_DATA = 7'd48;
    localparam logic [6:0] BIT_LAST = 7'd63;

    typedef enum logic [2:0] {
        S_RST_HOLD, S_RST_WAIT, S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [6:0]          r_bit;
    logic [RCNT_W-1:0]   r_rcnt;
    logic [63:0]         r_tx;
    logic                r_wr;
    logic                r_ta2;
    logic [15:0]         r_rx;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [15:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_init_done;
    logic                r_mdc;
    logic                r_mdio_o;
    logic                r_mdio_t;
    logic                r_phy_resetn;

    logic [63:0]         w_frame;
    logic [63:0]         w_load;
    logic                w_skip_pre;
    logic [6:0]          w_next_bit;

    // Read frames carry 1s in TA/DATA; those bits are released, so the value is irrelevant.
    assign w_frame = {32'hFFFF_FFFF, 2'b01, (cmd_wr ? 2'b01 : 2'b10), cmd_phy_addr,
                      cmd_reg_addr, (cmd_wr ? 2'b10 : 2'b11), (cmd_wr ? cmd_wdata : 16'hFFFF)};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic r_first;
    assign w_skip_pre = cfg_pre_sup & ~r_first;
`else
    assign w_skip_pre = 1'b0;
`endif

    assign w_load     = w_skip_pre ? {w_frame[31:0], 32'hFFFF_FFFF} : w_frame;
    assign w_next_bit = r_bit + 7'd1;

    function automatic state_t bit_state(input logic [6:0] b);
        if (b < BIT_HDR)       return S_PRE;
        else if (b < BIT_TA)   return S_HDR;
        else if (b < BIT_DATA) return S_TA;
        else                   return S_DATA;
    endfunction

    always_ff @(posedge clk_200) begin
        r_rsp_valid <= 1'b0;
        if (reset) begin
            r_state      <= S_RST_HOLD;
            r_div        <= '0;
            r_bit        <= '0;
            r_rcnt       <= '0;
            r_tx         <= '0;
            r_wr         <= 1'b0;
            r_ta2        <= 1'b0;
            r_rx         <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_init_done  <= 1'b0;
            r_mdc        <= 1'b0;
            r_mdio_o     <= 1'b1;
            r_mdio_t     <= 1'b1;
            r_phy_resetn <= 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            r_first      <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_RST_HOLD: begin
                    if (r_rcnt == HOLD_LAST) begin
                        r_state      <= S_RST_WAIT;
                        r_rcnt       <= '0;
                        r_phy_resetn <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + RCNT_W'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (r_rcnt == WAIT_LAST) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + RCNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        // First bit goes out immediately; MDC starts low so this acts as a falling edge.
                        r_cmd_ready <= 1'b0;
                        r_wr        <= cmd_wr;
                        r_tx        <= w_load;
                        r_mdio_o    <= w_load[63];
                        r_mdio_t    <= 1'b0;
                        r_div       <= '0;
                        r_mdc       <= 1'b0;
                        r_bit       <= w_skip_pre ? BIT_HDR : 7'd0;
                        r_state     <= w_skip_pre ? S_HDR : S_PRE;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                        r_first     <= 1'b0;
`endif
                    end
                end
                S_PRE, S_HDR, S_TA, S_DATA: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        r_mdc <= ~r_mdc;
                        if (!r_mdc) begin
                            if (r_bit == BIT_TA2)  r_ta2 <= mdio_phy_mdio_i;
                            if (r_bit >= BIT_DATA) r_rx  <= {r_rx[14:0], mdio_phy_mdio_i};
                        end else if (r_bit == BIT_LAST) begin
                            r_state     <= S_DONE;
                            r_mdio_o    <= 1'b1;
                            r_mdio_t    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ~r_wr & r_ta2;
                            if (!r_wr) r_rsp_rdata <= r_rx;
                        end else begin
                            r_bit    <= w_next_bit;
                            r_state  <= bit_state(w_next_bit);
                            r_tx     <= {r_tx[62:0], 1'b0};
                            r_mdio_o <= r_tx[62];
                            r_mdio_t <= ~r_wr & (w_next_bit >= BIT_TA);
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= S_RST_HOLD;
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign init_done       = r_init_done;
    assign mdio_phy_mdc    = r_mdc;
    assign mdio_phy_mdio_o = r_mdio_o;
    assign mdio_phy_mdio_t = r_mdio_t;
    assign phy_resetn      = r_phy_resetn;
endmodule
